rom_arbiter_n: RTL and testbench
================================

Name: rom_arbiter_n

Overview:
- N-channel SDRAM read arbiter with a download write path. Replaces the fixed 4-ROM mux in the ROM controller.
- Sits between the per-ROM segment caches (req/addr/ack/valid per channel) and the 32-bit SDRAM controller.
- Adds a registered request stage and an in-order tag FIFO, so several reads can be outstanding. Responses are routed by tag, not by a single pending register.
- Priority is fixed by channel index (channel 0 highest) unless the optional round-robin feature is compiled in.

Parameters:
- NUM_CH, 4, number of read channels (2..8).
- ADDR_WIDTH, 23, SDRAM word address width.
- DATA_WIDTH, 32, SDRAM data width.
- PEND_DEPTH, 4, tag FIFO depth: max reads acked but not yet valid (power of 2, 2..8).
- CH_W, $clog2(NUM_CH), tag width (derived; do not override).

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- ch_req  in  NUM_CH  per-channel read request, level, held until ch_ack.
- ch_addr  in  NUM_CH*ADDR_WIDTH  per-channel address; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- ch_ack  out  NUM_CH  one-cycle pulse: the request of channel i was accepted by SDRAM.
- ch_valid  out  NUM_CH  one-cycle pulse: sdram_q holds data for channel i.
- dl_active  in  1  download mode; blocks new reads.
- dl_req  in  1  download word ready, pulse.
- dl_addr  in  ADDR_WIDTH  download word address.
- dl_data  in  DATA_WIDTH  download word data.
- sdram_addr  out  ADDR_WIDTH  registered address.
- sdram_data  out  DATA_WIDTH  registered write data.
- sdram_we  out  1  registered write enable.
- sdram_req  out  1  registered request, held until sdram_ack.
- sdram_ack  in  1  request accepted.
- sdram_valid  in  1  read data valid.
- sdram_q  in  DATA_WIDTH  read data; not re-registered by this block.
- err_orphan  out  1  sticky: sdram_valid arrived with the tag FIFO empty.

Behaviour:
- Reset values: every output is 0, the FIFO is empty, the FSM is in IDLE, and the RR pointer is 0.
- FSM states: IDLE, RD_REQ, WR_REQ.
- IDLE -> WR_REQ: dl_active and dl_req. Latch dl_addr and dl_data; set sdram_we=1 and sdram_req=1 on the next edge.
- IDLE -> RD_REQ: not dl_active, some ch_req set, FIFO not full.
  - Grant the winner: lowest index, or the RR winner.
  - Register sdram_addr = ch_addr[winner] and the grant tag; set sdram_we=0 and sdram_req=1.
  - Latency from ch_req to sdram_req is 1 cycle.
- RD_REQ, on sdram_ack:
  - Pulse ch_ack[tag] in the same cycle (combinational from sdram_ack and the registered tag).
  - Push the tag; drop sdram_req; return to IDLE.
  - The next grant may issue on the following edge, giving back-to-back requests every 2 cycles.
- WR_REQ, on sdram_ack: drop sdram_req and sdram_we; return to IDLE. No tag is pushed.
- Request stability: sdram_addr, sdram_data and sdram_we are stable from sdram_req rise until sdram_ack. A change of ch_req or ch_addr while in RD_REQ is ignored.
- Response routing, on sdram_valid with the FIFO not empty:
  - Pulse ch_valid[head tag] in the same cycle (combinational) and pop.
  - A push and a pop in the same cycle is legal; the count is unchanged.
- Orphan response: sdram_valid with the FIFO empty sets err_orphan, pulses no ch_valid, and leaves the count unchanged.
- FIFO full: no RD_REQ issue; ch_req waits. WR_REQ is unaffected.
- dl_active rising while in RD_REQ: the current read completes normally. In-flight valids are still routed. Afterwards only WR_REQ can be entered.
- dl_req while not IDLE: ignored. The source guarantees spacing of at least 3 cycles.
- Reset mid-operation: asynchronous clear of all state. Pending tags are discarded; no ch_valid is issued for them.
- FIFO pointers: CLOG2(PEND_DEPTH) bits each, with a separate count register of width CLOG2(PEND_DEPTH)+1; wrap is natural.

Optional Feature:
- Macro: ROM_ARB_ROUND_ROBIN_EN.
- Defined: the grant searches from rr_ptr upward, modulo NUM_CH. rr_ptr <= winner+1 (wrapping) on each ch_ack. This is starvation-free.
- Undefined: fixed priority, channel 0 highest. rr_ptr is not implemented.

Decomposition:
- Package rom_arb_pkg holds:
  - FSM state enum (IDLE, RD_REQ, WR_REQ).
  - a CLOG2 constant function.
  - default parameter constants.
- One natural sub-module: rom_arb_tag_fifo, a synchronous FIFO with parameters width CH_W and depth PEND_DEPTH.
  - Outputs: full, empty, head.
  - Allows push and pop in the same cycle.

Test Plan:
- Single read: ch_req=4'b0100 with ch_addr[2]=0x12345.
  - sdram_req=1 with sdram_addr=0x12345 one cycle later.
  - Ack at t+3 -> ch_ack=4'b0100 for 1 cycle.
  - Valid at t+6 -> ch_valid=4'b0100 for 1 cycle.
- Fixed priority: ch_req=4'b1111 held, and each channel drops ch_req on its own ack (macro off).
  - Acks in order 0001, 0010, 0100, 1000.
  - Valids follow the same order.
- Pipelining and full: PEND_DEPTH=4, 5 requests issued, valid withheld.
  - 4 acks, then sdram_req stays 0.
  - First valid -> pop; the 5th request issues next cycle.
- Simultaneous push/pop: ack and valid in the same cycle with count=2.
  - count stays 2; tags are routed correctly.
- Download: dl_active=1, dl_req with dl_addr=0x00010 and dl_data=0xDEADBEEF, while ch_req=4'b0001.
  - sdram_we=1, sdram_req=1, sdram_data=0xDEADBEEF.
  - No ch_ack until dl_active=0.
- Orphan and reset: sdram_valid with the FIFO empty -> err_orphan=1.
  - Then assert reset mid RD_REQ -> all outputs 0 immediately (asynchronous).
  - Macro on: ch_req=4'b0011 held -> acks alternate 0001, 0010, 0001.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared types and defaults for the N-channel SDRAM read arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    WR_REQ
  } arb_state_t;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_ADDR_WIDTH = 23;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PEND_DEPTH = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rom_arb_tag_fifo.sv
// In-order tag FIFO: head is visible combinationally, push/pop take effect on the next edge.
// Push and pop may share a cycle; a push into a full FIFO is dropped unless a pop frees a slot.
module rom_arb_tag_fifo
  import rom_arb_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = clog2(DEPTH);

  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rom_arbiter_n.sv
// N-channel SDRAM read arbiter with download write path; ch_req -> sdram_req in 1 cycle, ack/valid routed combinationally.
// Reads stall while the tag FIFO is full or dl_active is set; ROM_ARB_ROUND_ROBIN_EN selects round-robin grant.
module rom_arbiter_n
  import rom_arb_pkg::*;
#(
  parameter int  NUM_CH     = DEF_NUM_CH,
  parameter int  ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  PEND_DEPTH = DEF_PEND_DEPTH,
  localparam int CH_W       = clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  output logic [NUM_CH-1:0]            ch_ack,
  output logic [NUM_CH-1:0]            ch_valid,
  input  logic                         dl_active,
  input  logic                         dl_req,
  input  logic [ADDR_WIDTH-1:0]        dl_addr,
  input  logic [DATA_WIDTH-1:0]        dl_data,
  output logic [ADDR_WIDTH-1:0]        sdram_addr,
  output logic [DATA_WIDTH-1:0]        sdram_data,
  output logic                         sdram_we,
  output logic                         sdram_req,
  input  logic                         sdram_ack,
  input  logic                         sdram_valid,
  input  logic [DATA_WIDTH-1:0]        sdram_q,
  output logic                         err_orphan
);

  arb_state_t      state;
  arb_state_t      state_nxt;
  logic [CH_W-1:0] tag;
  logic [CH_W-1:0] winner;
  logic            any_req;
  logic            issue_rd;
  logic            issue_wr;
  logic            done;
  logic            rd_ack;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CH_W-1:0] fifo_head;
  logic            unused_q;

  // Read data goes straight from the SDRAM to the caches.
  assign unused_q = ^sdram_q;

  assign rd_ack = (state == RD_REQ) && sdram_ack;
  assign pop    = sdram_valid && !fifo_empty;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0] rr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rr_ptr <= '0;
    else if (rd_ack) rr_ptr <= (tag == CH_W'(NUM_CH-1)) ? '0 : tag + 1'b1;
  end

  // Scan downward so the last hit is the first requester at or above rr_ptr.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      if (ch_req[(int'(rr_ptr) + k) % NUM_CH]) begin
        any_req = 1'b1;
        winner  = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end
`else
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int k = NUM_CH-1; k >= 0; k--) begin
      if (ch_req[k]) begin
        any_req = 1'b1;
        winner  = CH_W'(k);
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A pop in the same cycle frees a slot, so a full FIFO does not cost an extra cycle.
  always_comb begin
    state_nxt = state;
    issue_rd  = 1'b0;
    issue_wr  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (dl_active && dl_req) begin
          issue_wr  = 1'b1;
          state_nxt = WR_REQ;
        end else if (!dl_active && any_req && (!fifo_full || pop)) begin
          issue_rd  = 1'b1;
          state_nxt = RD_REQ;
        end
      end
      RD_REQ, WR_REQ: begin
        if (sdram_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_we   <= 1'b0;
      sdram_req  <= 1'b0;
      tag        <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (issue_rd) begin
        sdram_addr <= ch_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        sdram_we   <= 1'b0;
        sdram_req  <= 1'b1;
        tag        <= winner;
      end else if (issue_wr) begin
        sdram_addr <= dl_addr;
        sdram_data <= dl_data;
        sdram_we   <= 1'b1;
        sdram_req  <= 1'b1;
      end else if (done) begin
        sdram_we   <= 1'b0;
        sdram_req  <= 1'b0;
      end
      if (sdram_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end

  always_comb begin
    ch_ack   = '0;
    ch_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ack[i]   = rd_ack && (tag == CH_W'(i));
      ch_valid[i] = pop && (fifo_head == CH_W'(i));
    end
  end

  rom_arb_tag_fifo #(
    .WIDTH(CH_W),
    .DEPTH(PEND_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rd_ack),
    .push_data(tag),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_rom_arbiter_n.sv
// Randomized bench for rom_arbiter_n against a queue-based transaction model, plus directed scenarios.
module tb_rom_arbiter_n;
  localparam int NUM_CH = 4;
  localparam int AW     = 23;
  localparam int DW     = 32;
  localparam int DEPTH  = 4;
`ifdef ROM_ARB_ROUND_ROBIN_EN
  localparam int RR = 1;
`else
  localparam int RR = 0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_CH-1:0]      ch_req;
  logic [NUM_CH*AW-1:0]   ch_addr;
  logic [NUM_CH-1:0]      ch_ack;
  logic [NUM_CH-1:0]      ch_valid;
  logic                   dl_active;
  logic                   dl_req;
  logic [AW-1:0]          dl_addr;
  logic [DW-1:0]          dl_data;
  logic [AW-1:0]          sdram_addr;
  logic [DW-1:0]          sdram_data;
  logic                   sdram_we;
  logic                   sdram_req;
  logic                   sdram_ack;
  logic                   sdram_valid;
  logic [DW-1:0]          sdram_q;
  logic                   err_orphan;

  int checks = 0;
  int errors = 0;

  bit            m_req, m_we, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            m_tag, m_rr;
  int            pend_q[$];

  logic [NUM_CH-1:0] last_ack, last_valid, last_eack;
  logic [NUM_CH-1:0] got [8];
  logic [NUM_CH-1:0] exp4 [4];

  always #5 clk = ~clk;

  rom_arbiter_n #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PEND_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ch_req(ch_req), .ch_addr(ch_addr), .ch_ack(ch_ack),
    .ch_valid(ch_valid), .dl_active(dl_active), .dl_req(dl_req), .dl_addr(dl_addr),
    .dl_data(dl_data), .sdram_addr(sdram_addr), .sdram_data(sdram_data), .sdram_we(sdram_we),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_valid(sdram_valid), .sdram_q(sdram_q),
    .err_orphan(err_orphan)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 0; m_we = 0; m_err = 0; m_addr = '0; m_data = '0; m_tag = 0; m_rr = 0;
    pend_q.delete();
    last_eack = '0;
  endtask

  // First requesting channel in search order starting at rr (rr ignored for fixed priority).
  function automatic int grant(input logic [NUM_CH-1:0] r, input int rr);
    for (int k = 0; k < NUM_CH; k++) begin
      int i = (rr * RR + k) % NUM_CH;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  // Called at posedge+1 with this cycle's inputs applied; returns at the next posedge+1.
  task automatic tick();
    logic [NUM_CH-1:0] ea, ev;
    bit pop;
    int w;
    #1;
    ea = '0;
    ev = '0;
    if (m_req && !m_we && sdram_ack) ea[m_tag] = 1'b1;
    pop = sdram_valid && (pend_q.size() > 0);
    if (pop) ev[pend_q[0]] = 1'b1;
    last_ack   = ch_ack;
    last_valid = ch_valid;
    last_eack  = ea;
    chk("ch_ack", ch_ack, ea);
    chk("ch_valid", ch_valid, ev);
    if (sdram_valid) begin
      if (pop) void'(pend_q.pop_front());
      else     m_err = 1;
    end
    if (m_req) begin
      if (sdram_ack) begin
        if (!m_we) begin
          pend_q.push_back(m_tag);
          m_rr = (m_tag + 1) % NUM_CH;
        end
        m_req = 0;
        m_we  = 0;
      end
    end else if (dl_active && dl_req) begin
      m_req = 1; m_we = 1; m_addr = dl_addr; m_data = dl_data;
    end else if (!dl_active) begin
      w = grant(ch_req, m_rr);
      if (w >= 0 && pend_q.size() < DEPTH) begin
        m_req = 1; m_we = 0; m_tag = w;
        m_addr = ch_addr[w*AW +: AW];
      end
    end
    @(posedge clk);
    #1;
    chk("sdram_req", sdram_req, m_req);
    chk("sdram_we", sdram_we, m_we);
    chk("sdram_addr", sdram_addr, m_addr);
    chk("sdram_data", sdram_data, m_data);
    chk("err_orphan", err_orphan, m_err);
  endtask

  task automatic zero_check(input string nm);
    chk({nm, "_req"}, sdram_req, 0);
    chk({nm, "_we"}, sdram_we, 0);
    chk({nm, "_addr"}, sdram_addr, 0);
    chk({nm, "_data"}, sdram_data, 0);
    chk({nm, "_err"}, err_orphan, 0);
    chk({nm, "_ack"}, ch_ack, 0);
    chk({nm, "_valid"}, ch_valid, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    ch_req = '0; dl_active = 0; dl_req = 0; sdram_ack = 0; sdram_valid = 0;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic drive_acks(input int n, input bit drop, input bit give_valid);
    int k;
    k = 0;
    for (int c = 0; c < 40 && k < n; c++) begin
      sdram_ack   = m_req;
      sdram_valid = give_valid && (pend_q.size() > 0);
      tick();
      if (last_ack != '0) begin
        got[k] = last_ack;
        k++;
      end
      if (drop) ch_req &= ~last_eack;
    end
    sdram_ack   = 0;
    sdram_valid = 0;
    chk("ack_count", k, n);
  endtask

  initial begin
    logic [NUM_CH-1:0] acc;
    int cool;
    reset = 1;
    ch_req = '0; ch_addr = '0; dl_active = 0; dl_req = 0; dl_addr = '0; dl_data = '0;
    sdram_ack = 0; sdram_valid = 0; sdram_q = '0;
    model_reset();
    #2;
    zero_check("reset");
    @(posedge clk);
    #1;
    reset = 0;

    // Single read on channel 2
    ch_req = 4'b0100;
    ch_addr[2*AW +: AW] = 23'h12345;
    tick();
    chk("single_req", sdram_req, 1);
    chk("single_addr", sdram_addr, 23'h12345);
    tick();
    tick();
    sdram_ack = 1;
    tick();
    chk("single_ack", last_ack, 4'b0100);
    sdram_ack = 0;
    ch_req = '0;
    tick();
    tick();
    sdram_valid = 1;
    tick();
    chk("single_valid", last_valid, 4'b0100);
    sdram_valid = 0;

    // Fixed-priority order, then FIFO full and release on first valid
    do_reset();
    ch_req = 4'b1111;
    drive_acks(4, 1, 0);
    chk("prio_ack0", got[0], 4'b0001);
    chk("prio_ack1", got[1], 4'b0010);
    chk("prio_ack2", got[2], 4'b0100);
    chk("prio_ack3", got[3], 4'b1000);
    ch_req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      sdram_ack = m_req;
      tick();
      chk("full_stall", sdram_req, 0);
    end
    sdram_ack = 0;
    sdram_valid = 1;
    tick();
    chk("full_pop_valid", last_valid, 4'b0001);
    chk("full_reissue", sdram_req, 1);
    sdram_valid = 0;
    drive_acks(1, 1, 0);
    chk("fifth_ack", got[0], 4'b0001);
    exp4 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    sdram_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("prio_valid_order", last_valid, exp4[i]);
    end
    sdram_valid = 0;

    // Push and pop in the same cycle with two outstanding
    do_reset();
    ch_req = 4'b0011;
    drive_acks(2, 1, 0);
    chk("pp_ack0", got[0], 4'b0001);
    chk("pp_ack1", got[1], 4'b0010);
    ch_req = 4'b0100;
    tick();
    sdram_ack = 1;
    sdram_valid = 1;
    tick();
    chk("pp_ack", last_ack, 4'b0100);
    chk("pp_valid", last_valid, 4'b0001);
    chk("pp_count", dut.u_fifo.count, 2);
    sdram_ack = 0;
    ch_req = '0;
    tick();
    chk("pp_valid1", last_valid, 4'b0010);
    tick();
    chk("pp_valid2", last_valid, 4'b0100);
    sdram_valid = 0;

    // Download write blocks reads
    do_reset();
    dl_active = 1;
    ch_req = 4'b0001;
    dl_req = 1;
    dl_addr = 23'h00010;
    dl_data = 32'hDEADBEEF;
    tick();
    dl_req = 0;
    chk("dl_we", sdram_we, 1);
    chk("dl_req", sdram_req, 1);
    chk("dl_data", sdram_data, 32'hDEADBEEF);
    chk("dl_addr", sdram_addr, 23'h00010);
    acc = '0;
    tick();
    acc |= last_ack;
    tick();
    acc |= last_ack;
    sdram_ack = 1;
    tick();
    acc |= last_ack;
    sdram_ack = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      acc |= last_ack;
    end
    chk("dl_no_ack", acc, 0);
    chk("dl_no_read", sdram_req, 0);
    dl_active = 0;
    drive_acks(1, 1, 0);
    chk("dl_after_ack", got[0], 4'b0001);

    // Orphan response, then asynchronous reset mid read with a pending tag
    sdram_valid = 1;
    tick();
    chk("orph_pre_valid", last_valid, 4'b0001);
    tick();
    chk("orph_valid", last_valid, 0);
    chk("orph_err", err_orphan, 1);
    sdram_valid = 0;
    ch_req = 4'b0010;
    drive_acks(1, 1, 0);
    ch_req = 4'b0100;
    tick();
    chk("rst_in_rd", sdram_req, 1);
    reset = 1;
    sdram_ack = 1;
    sdram_valid = 1;
    #1;
    zero_check("async_rst");
    sdram_ack = 0;
    sdram_valid = 0;
    ch_req = '0;
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    sdram_valid = 1;
    tick();
    chk("rst_discard", last_valid, 0);
    chk("rst_orph_err", err_orphan, 1);
    sdram_valid = 0;

    // Two channels held continuously
    do_reset();
    ch_req = 4'b0011;
    drive_acks(3, 0, 1);
    chk("hold_ack0", got[0], 4'b0001);
    chk("hold_ack1", got[1], RR ? 4'b0010 : 4'b0001);
    chk("hold_ack2", got[2], 4'b0001);
    ch_req = '0;
    sdram_valid = 1;
    for (int c = 0; c < 10 && pend_q.size() > 0; c++) tick();
    sdram_valid = 0;

    // Randomized traffic
    do_reset();
    cool = 0;
    for (int c = 0; c < 3000; c++) begin
      ch_req &= ~last_eack;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_req[i] && $urandom_range(3) == 0) begin
          ch_req[i] = 1'b1;
          ch_addr[i*AW +: AW] = AW'($urandom);
        end else if ($urandom_range(7) == 0) begin
          ch_addr[i*AW +: AW] = AW'($urandom);
        end
      end
      if ($urandom_range(63) == 0) dl_active = ~dl_active;
      dl_req = 0;
      if (cool > 0) cool--;
      else if ($urandom_range(3) == 0) begin
        dl_req = 1;
        cool = 3;
        dl_addr = AW'($urandom);
        dl_data = $urandom;
      end
      sdram_ack = m_req && ($urandom_range(2) == 0);
      sdram_valid = (pend_q.size() > 0) ? ($urandom_range(2) == 0) : ($urandom_range(199) == 0);
      sdram_q = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
